// File: rtl/pc_pkg.sv
// Shared constants and helpers for the PC sequencer: parameter defaults,
// command codes in priority order, and branch-offset sign extension.
package pc_pkg;

    localparam int          ADDR_W_DEF      = 8;
    localparam int          OFF_W_DEF       = 5;
    localparam int          STACK_DEPTH_DEF = 4;
    localparam logic [15:0] RESET_VEC_DEF   = 16'h0000;

    localparam logic [2:0] CMD_HOLD   = 3'd0;
    localparam logic [2:0] CMD_RET    = 3'd1;
    localparam logic [2:0] CMD_CALL   = 3'd2;
    localparam logic [2:0] CMD_LOAD   = 3'd3;
    localparam logic [2:0] CMD_BRANCH = 3'd4;
    localparam logic [2:0] CMD_INC    = 3'd5;

    // Highest-priority command wins; the rest are dropped. Stall is handled by the caller.
    function automatic logic [2:0] cmd_select(input logic ret, input logic call,
                                              input logic load, input logic branch,
                                              input logic inc);
        logic [2:0] cmd;
        if (ret)         cmd = CMD_RET;
        else if (call)   cmd = CMD_CALL;
        else if (load)   cmd = CMD_LOAD;
        else if (branch) cmd = CMD_BRANCH;
        else if (inc)    cmd = CMD_INC;
        else             cmd = CMD_HOLD;
        return cmd;
    endfunction

    // Replicates bit off_w-1 of a zero-extended raw offset into the upper bits.
    function automatic logic [15:0] sext_off(input logic [15:0] raw, input int off_w);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) begin
            r[i] = (i < off_w) ? raw[i] : raw[off_w-1];
        end
        return r;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Command/status bundle between the control unit (master) and the PC sequencer (slave).
interface pc_sequencer_if
    import pc_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int OFF_W  = OFF_W_DEF
);
    logic              stall;
    logic              pc_inc;
    logic              pc_load;
    logic [ADDR_W-1:0] load_addr;
    logic              pc_branch;
    logic [OFF_W-1:0]  br_off;
    logic              call;
    logic              ret;
    logic [ADDR_W-1:0] pc;
    logic              stk_empty;
    logic              stk_full;
    logic              err_ovf;
    logic              err_unf;

    modport master (
        output stall, pc_inc, pc_load, load_addr, pc_branch, br_off, call, ret,
        input  pc, stk_empty, stk_full, err_ovf, err_unf
    );

    modport slave (
        input  stall, pc_inc, pc_load, load_addr, pc_branch, br_off, call, ret,
        output pc, stk_empty, stk_full, err_ovf, err_unf
    );
endinterface

// File: rtl/pc_ret_stack.sv
// Hardware return-address LIFO. Push/pop requests against full/empty are ignored;
// entries are plain registers with no reset since contents are don't-care when empty.
module pc_ret_stack
    import pc_pkg::*;
#(
    parameter int  DEPTH = STACK_DEPTH_DEF,
    parameter int  WIDTH = ADDR_W_DEF,
    localparam int IDX_W = $clog2(DEPTH),
    localparam int CNT_W = IDX_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] top,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic             do_push;
    logic             do_pop;
    logic [IDX_W-1:0] top_idx;
    logic [WIDTH-1:0] entry_q [DEPTH];

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && !full && !do_pop;
    assign top_idx = IDX_W'(count_reg - CNT_W'(1));
    assign top     = entry_q[top_idx];
    assign count   = count_reg;

    always_comb begin
        count_next = count_reg;
        if (do_pop)       count_next = count_reg - CNT_W'(1);
        else if (do_push) count_next = count_reg + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) count_reg <= '0;
        else     count_reg <= count_next;
    end

    // While not full, the low IDX_W bits of count name the next free slot.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : gen_entry
            logic [WIDTH-1:0] entry_reg;
            always_ff @(posedge clk) begin
                if (do_push && (count_reg[IDX_W-1:0] == IDX_W'(gi)))
                    entry_reg <= data_in;
            end
            assign entry_q[gi] = entry_reg;
        end
    endgenerate

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: increment, absolute load, relative branch and
// call/return via pc_ret_stack, with one-cycle overflow/underflow error pulses.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int                ADDR_W      = ADDR_W_DEF,
    parameter int                OFF_W       = OFF_W_DEF,
    parameter int                STACK_DEPTH = STACK_DEPTH_DEF,
    parameter logic [ADDR_W-1:0] RESET_VEC   = ADDR_W'(RESET_VEC_DEF)
) (
    input  logic          clk,
    input  logic          rst,
    pc_sequencer_if.slave bus
);
    localparam int CNT_W = $clog2(STACK_DEPTH) + 1;

    logic [ADDR_W-1:0] pc_reg;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] pc_plus1;
    logic [ADDR_W-1:0] pc_br;
    logic [ADDR_W-1:0] stk_top;
    logic [CNT_W-1:0]  stk_count;
    logic              stk_empty_w;
    logic              stk_full_w;
    logic              push;
    logic              pop;
    logic              err_ovf_reg;
    logic              err_ovf_next;
    logic              err_unf_reg;
    logic              err_unf_next;
    logic [2:0]        cmd;

    assign pc_plus1 = pc_reg + ADDR_W'(1);
    assign pc_br    = ADDR_W'(16'(pc_reg) + sext_off(16'(bus.br_off), OFF_W));
    assign cmd      = bus.stall ? CMD_HOLD
                                : cmd_select(bus.ret, bus.call, bus.pc_load,
                                             bus.pc_branch, bus.pc_inc);

    always_comb begin
        pc_next      = pc_reg;
        push         = 1'b0;
        pop          = 1'b0;
        err_ovf_next = 1'b0;
        err_unf_next = 1'b0;
        case (cmd)
            CMD_RET: begin
                if (!stk_empty_w) begin
                    pc_next = stk_top;
                    pop     = 1'b1;
                end else begin
                    err_unf_next = 1'b1;
                end
            end
            CMD_CALL: begin
                if (!stk_full_w) begin
                    pc_next = bus.load_addr;
                    push    = 1'b1;
                end else begin
                    err_ovf_next = 1'b1;
                end
            end
            CMD_LOAD:   pc_next = bus.load_addr;
            CMD_BRANCH: pc_next = pc_br;
            CMD_INC:    pc_next = pc_plus1;
            default:    pc_next = pc_reg;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg      <= RESET_VEC;
            err_ovf_reg <= 1'b0;
            err_unf_reg <= 1'b0;
        end else begin
            pc_reg      <= pc_next;
            err_ovf_reg <= err_ovf_next;
            err_unf_reg <= err_unf_next;
        end
    end

    pc_ret_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (ADDR_W)
    ) u_stack (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .data_in (pc_plus1),
        .top     (stk_top),
        .count   (stk_count),
        .empty   (stk_empty_w),
        .full    (stk_full_w)
    );

    assign bus.pc        = pc_reg;
    assign bus.stk_empty = (stk_count == '0);
    assign bus.stk_full  = (stk_count == CNT_W'(STACK_DEPTH));
    assign bus.err_ovf   = err_ovf_reg;
    assign bus.err_unf   = err_unf_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: table of command vectors with expected
// outputs pushed to a scoreboard, plus hand sequences for reset and stack limits.
module tb_pc_sequencer;
    import pc_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pc_sequencer_if #(.ADDR_W(8), .OFF_W(5)) bus ();

    pc_sequencer #(
        .ADDR_W      (8),
        .OFF_W       (5),
        .STACK_DEPTH (4),
        .RESET_VEC   (8'h00)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       stall, inc, load;
        logic [7:0] addr;
        logic       branch;
        logic [4:0] off;
        logic       call, ret;
        logic [7:0] e_pc;
        logic       e_empty, e_full, e_ovf, e_unf;
    } vec_t;

    typedef struct {
        logic [7:0] pc;
        logic       empty, full, ovf, unf;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   step_no = 0;

    function automatic vec_t mk(input logic stall, input logic inc, input logic load,
                                input logic [7:0] addr, input logic branch,
                                input logic [4:0] off, input logic call, input logic ret,
                                input logic [7:0] e_pc, input logic e_empty,
                                input logic e_full, input logic e_ovf, input logic e_unf);
        vec_t v;
        v.stall = stall; v.inc = inc; v.load = load; v.addr = addr;
        v.branch = branch; v.off = off; v.call = call; v.ret = ret;
        v.e_pc = e_pc; v.e_empty = e_empty; v.e_full = e_full;
        v.e_ovf = e_ovf; v.e_unf = e_unf;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, step_no, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus.stall = 0; bus.pc_inc = 0; bus.pc_load = 0; bus.load_addr = 8'h00;
        bus.pc_branch = 0; bus.br_off = 5'h00; bus.call = 0; bus.ret = 0;
    endtask

    // Drive one command at the falling edge, let the rising edge take it, compare at the next falling edge.
    task automatic step(input vec_t v);
        exp_t e;
        bus.stall = v.stall; bus.pc_inc = v.inc; bus.pc_load = v.load;
        bus.load_addr = v.addr; bus.pc_branch = v.branch; bus.br_off = v.off;
        bus.call = v.call; bus.ret = v.ret;
        e.pc = v.e_pc; e.empty = v.e_empty; e.full = v.e_full;
        e.ovf = v.e_ovf; e.unf = v.e_unf;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        e = sb.pop_front();
        $display("step %0d: stl=%b inc=%b ld=%b br=%b call=%b ret=%b addr=%h off=%h -> pc=%h emp=%b full=%b ovf=%b unf=%b",
                 step_no, v.stall, v.inc, v.load, v.branch, v.call, v.ret, v.addr, v.off,
                 bus.pc, bus.stk_empty, bus.stk_full, bus.err_ovf, bus.err_unf);
        check("pc", bus.pc, e.pc);
        check("stk_empty", 8'(bus.stk_empty), 8'(e.empty));
        check("stk_full", 8'(bus.stk_full), 8'(e.full));
        check("err_ovf", 8'(bus.err_ovf), 8'(e.ovf));
        check("err_unf", 8'(bus.err_unf), 8'(e.unf));
        step_no++;
    endtask

    vec_t tbl[28];

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // st inc ld addr br off call ret | pc emp full ovf unf
        tbl[0]  = mk(0,0,1,8'hFE,0,5'h00,0,0, 8'hFE,1,0,0,0);
        tbl[1]  = mk(0,1,0,8'h00,0,5'h00,0,0, 8'hFF,1,0,0,0);
        tbl[2]  = mk(0,1,0,8'h00,0,5'h00,0,0, 8'h00,1,0,0,0);
        tbl[3]  = mk(0,1,0,8'h00,0,5'h00,0,0, 8'h01,1,0,0,0);
        tbl[4]  = mk(0,0,1,8'h10,0,5'h00,0,0, 8'h10,1,0,0,0);
        tbl[5]  = mk(0,0,0,8'h00,1,5'h1C,0,0, 8'h0C,1,0,0,0);
        tbl[6]  = mk(0,0,1,8'h02,0,5'h00,0,0, 8'h02,1,0,0,0);
        tbl[7]  = mk(0,0,0,8'h00,1,5'h1C,0,0, 8'hFE,1,0,0,0);
        tbl[8]  = mk(0,0,1,8'h20,0,5'h00,0,0, 8'h20,1,0,0,0);
        tbl[9]  = mk(0,0,0,8'h40,0,5'h00,1,0, 8'h40,0,0,0,0);
        tbl[10] = mk(0,0,0,8'h80,0,5'h00,1,0, 8'h80,0,0,0,0);
        tbl[11] = mk(0,0,0,8'h00,0,5'h00,0,1, 8'h41,0,0,0,0);
        tbl[12] = mk(0,0,0,8'h00,0,5'h00,0,1, 8'h21,1,0,0,0);
        tbl[13] = mk(0,0,0,8'h00,0,5'h00,0,0, 8'h21,1,0,0,0);
        tbl[14] = mk(0,0,0,8'h00,1,5'h0F,0,0, 8'h30,1,0,0,0);
        tbl[15] = mk(0,1,0,8'h50,0,5'h00,1,0, 8'h50,0,0,0,0);
        tbl[16] = mk(0,1,1,8'h99,0,5'h00,1,1, 8'h31,1,0,0,0);
        tbl[17] = mk(1,0,1,8'h77,0,5'h00,0,0, 8'h31,1,0,0,0);
        tbl[18] = mk(1,0,0,8'h00,0,5'h00,0,1, 8'h31,1,0,0,0);
        tbl[19] = mk(0,0,0,8'h00,0,5'h00,0,1, 8'h31,1,0,0,1);
        tbl[20] = mk(0,0,0,8'h00,0,5'h00,0,0, 8'h31,1,0,0,0);
        tbl[21] = mk(0,0,1,8'hFF,0,5'h00,0,0, 8'hFF,1,0,0,0);
        tbl[22] = mk(0,0,0,8'h10,0,5'h00,1,0, 8'h10,0,0,0,0);
        tbl[23] = mk(0,0,0,8'h00,0,5'h00,0,1, 8'h00,1,0,0,0);
        tbl[24] = mk(0,0,0,8'h00,1,5'h10,0,0, 8'hF0,1,0,0,0);
        tbl[25] = mk(0,0,1,8'h31,0,5'h00,0,0, 8'h31,1,0,0,0);
        tbl[26] = mk(0,0,1,8'h44,1,5'h01,0,0, 8'h44,1,0,0,0);
        tbl[27] = mk(0,1,0,8'h00,1,5'h01,0,0, 8'h45,1,0,0,0);

        drive_idle();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_pc", bus.pc, 8'h00);
        check("reset_empty", 8'(bus.stk_empty), 8'h01);
        check("reset_full", 8'(bus.stk_full), 8'h00);
        rst = 1'b0;

        // Reset mid-run with a pending stack entry: asynchronous return to reset values.
        step(mk(0,0,1,8'h37,0,5'h00,0,0, 8'h37,1,0,0,0));
        step(mk(0,0,0,8'h40,0,5'h00,1,0, 8'h40,0,0,0,0));
        drive_idle();
        #2 rst = 1'b1;
        #1;
        check("async_rst_pc", bus.pc, 8'h00);
        check("async_rst_empty", 8'(bus.stk_empty), 8'h01);
        check("async_rst_ovf", 8'(bus.err_ovf), 8'h00);
        check("async_rst_unf", 8'(bus.err_unf), 8'h00);
        @(negedge clk);
        rst = 1'b0;
        step(mk(0,0,0,8'h00,0,5'h00,0,0, 8'h00,1,0,0,0));
        step(mk(0,0,0,8'h00,0,5'h00,0,1, 8'h00,1,0,0,1));

        foreach (tbl[i]) step(tbl[i]);

        // Fill the stack from pc=0x45: pushes 0x46, 0xA1, 0xA2, 0xA3.
        for (int i = 0; i < 4; i++) begin
            step(mk(0,0,0,8'hA0 + 8'(i),0,5'h00,1,0, 8'hA0 + 8'(i),0,(i == 3),0,0));
        end
        step(mk(0,0,0,8'hB0,0,5'h00,1,0, 8'hA3,0,1,1,0));
        step(mk(0,0,0,8'h00,0,5'h00,0,0, 8'hA3,0,1,0,0));
        step(mk(1,0,0,8'hB1,0,5'h00,1,0, 8'hA3,0,1,0,0));
        step(mk(0,0,0,8'h00,0,5'h00,0,1, 8'hA3,0,0,0,0));
        step(mk(0,0,0,8'h00,0,5'h00,0,1, 8'hA2,0,0,0,0));
        step(mk(0,0,0,8'h00,0,5'h00,0,1, 8'hA1,0,0,0,0));
        step(mk(0,0,0,8'h00,0,5'h00,0,1, 8'h46,1,0,0,0));
        step(mk(0,0,0,8'h00,0,5'h00,0,1, 8'h46,1,0,0,1));
        step(mk(0,0,0,8'h00,0,5'h00,0,0, 8'h46,1,0,0,0));

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
